pixel_replication_2x: RTL and testbench

- Streaming 2x upscaler by pixel replication (nearest-neighbour zoom); the counterpart of the 2x decimation downscaler.
- Consumes an IMG_WIDTH x IMG_HEIGHT frame in raster order and emits a 2*IMG_WIDTH x 2*IMG_HEIGHT frame, also in raster order.
- Each input pixel is emitted twice horizontally. Each input row is emitted twice vertically; the second copy is replayed from an internal line buffer.
- Sits between the frame source and the output writer in the scaling datapath, started by the main control FSM.

---
 rtl/pixel_replication_2x.sv | 148 ++++++++++++++
 tb/tb_pixel_replication_2x.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_replication_2x.sv
// 2x nearest-neighbour upscaler: each pixel emitted twice, each row replayed from a line buffer.
// Latency: one cycle from input accept to first output copy; DONE pulse one cycle after last transfer.
// Backpressure: out_ready stalls the registered output, in_ready drops until the held pixel is spent.
// Optional PIXEL_REPLICATION_COUNT_EN adds a 32-bit per-frame output transfer counter (out_count).
module pixel_replication_2x #(
   parameter int IMG_WIDTH  = 160,
   parameter int IMG_HEIGHT = 120
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [7:0]  pixel_in,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [7:0]  pixel_out,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
`ifdef PIXEL_REPLICATION_COUNT_EN
   output logic [31:0] out_count,
`endif
   output logic        done
);

   localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

   typedef enum logic [1:0] {IDLE, ROW_A, ROW_B, DONE} state_t;

   state_t        state;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic          dup;
   logic [7:0]    linebuf [IMG_WIDTH];

   logic          col_last;
   logic          in_xfer;
   logic          out_xfer;
   logic [CW-1:0] col_nxt;
   logic [CW-1:0] wr_idx;

   assign col_last = (col == COL_LAST);
   assign col_nxt  = col + CW'(1);
   // The last pixel of a row must not be chased by a new input: the row switches to replay instead.
   assign in_ready = (state == ROW_A) && (!out_valid || (out_ready && dup && !col_last));
   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;
   assign busy     = (state != IDLE);
   // A zero-bubble load lands in the next column, since col advances in the same cycle.
   assign wr_idx   = out_valid ? col_nxt : col;

   always_ff @(posedge clk) begin
      if (in_xfer) begin
         linebuf[wr_idx] <= pixel_in;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         pixel_out <= '0;
         out_valid <= 1'b0;
         done      <= 1'b0;
         col       <= '0;
         row       <= '0;
         dup       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= ROW_A;
                  col   <= '0;
                  row   <= '0;
                  dup   <= 1'b0;
                  done  <= 1'b0;
               end
            end
            ROW_A: begin
               if (out_xfer && dup && col_last) begin
                  state     <= ROW_B;
                  col       <= '0;
                  pixel_out <= linebuf[0];
                  out_valid <= 1'b1;
                  dup       <= 1'b0;
               end else begin
                  if (out_xfer) begin
                     if (!dup) begin
                        dup <= 1'b1;
                     end else begin
                        col       <= col_nxt;
                        out_valid <= 1'b0;
                     end
                  end
                  if (in_xfer) begin
                     pixel_out <= pixel_in;
                     out_valid <= 1'b1;
                     dup       <= 1'b0;
                  end
               end
            end
            ROW_B: begin
               if (out_xfer) begin
                  if (!dup) begin
                     dup <= 1'b1;
                  end else if (!col_last) begin
                     col       <= col_nxt;
                     pixel_out <= linebuf[col_nxt];
                     dup       <= 1'b0;
                  end else begin
                     out_valid <= 1'b0;
                     col       <= '0;
                     dup       <= 1'b0;
                     if (row == ROW_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                     end else begin
                        row   <= row + RW'(1);
                        state <= ROW_A;
                     end
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef PIXEL_REPLICATION_COUNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_count <= '0;
      end else if (state == IDLE && start) begin
         out_count <= '0;
      end else if (out_xfer) begin
         out_count <= out_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pixel_replication_2x.sv
// Directed bench for pixel_replication_2x: a 4x2 instance for streaming scenarios and a 1x1 instance for the degenerate frame.
module tb_pixel_replication_2x;

   localparam int W     = 4;
   localparam int H     = 2;
   localparam int TOTAL = 4 * W * H;

   logic       clk = 1'b0;
   logic       reset_n;

   logic       start, in_valid, in_ready, out_valid, out_ready, busy, done;
   logic [7:0] pixel_in, pixel_out;
   logic       start1, in_valid1, in_ready1, out_valid1, out_ready1, busy1, done1;
   logic [7:0] pixel_in1, pixel_out1;
`ifdef PIXEL_REPLICATION_COUNT_EN
   logic [31:0] out_count, out_count1;
`endif

   always #5 clk = ~clk;

   pixel_replication_2x #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .pixel_in(pixel_in), .in_valid(in_valid), .in_ready(in_ready),
      .pixel_out(pixel_out), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy),
`ifdef PIXEL_REPLICATION_COUNT_EN
      .out_count(out_count),
`endif
      .done(done)
   );

   pixel_replication_2x #(.IMG_WIDTH(1), .IMG_HEIGHT(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .start(start1),
      .pixel_in(pixel_in1), .in_valid(in_valid1), .in_ready(in_ready1),
      .pixel_out(pixel_out1), .out_valid(out_valid1), .out_ready(out_ready1),
      .busy(busy1),
`ifdef PIXEL_REPLICATION_COUNT_EN
      .out_count(out_count1),
`endif
      .done(done1)
   );

   logic [7:0] src [W*H] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
   logic [7:0] exp_seq [TOTAL] = '{
      8'd10, 8'd10, 8'd20, 8'd20, 8'd30, 8'd30, 8'd40, 8'd40,
      8'd10, 8'd10, 8'd20, 8'd20, 8'd30, 8'd30, 8'd40, 8'd40,
      8'd50, 8'd50, 8'd60, 8'd60, 8'd70, 8'd70, 8'd80, 8'd80,
      8'd50, 8'd50, 8'd60, 8'd60, 8'd70, 8'd70, 8'd80, 8'd80};

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] got [$];
   int   hold_err, inrdy_err, rowb_err, starve_err, starve_seen, done_hi, done_lat;
   logic busy_after;

   // rmode 1: out_ready toggles 1,0,1,0. vmode 1: in_valid every 3rd cycle.
   // restart: pulse start once during ROW_B of row 0. stop_after>0: leave after that many transfers.
   task automatic run_frame(input int rmode, input int vmode, input int restart, input int stop_after);
      int   n, idx, t_last, done_cyc;
      logic prev_hold, expect_starve, restarted, phase_b, in_x, out_x;
      logic [7:0] prev_pix;
      got.delete();
      hold_err = 0; inrdy_err = 0; rowb_err = 0; starve_err = 0; starve_seen = 0;
      done_hi = 0; done_lat = -1; busy_after = 1'bx;
      n = 0; idx = 0; t_last = -100; done_cyc = -1;
      prev_hold = 1'b0; expect_starve = 1'b0; restarted = 1'b0; prev_pix = 8'h00;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         out_ready = (rmode == 1) ? (cyc % 2 == 0) : 1'b1;
         in_valid  = (idx < W*H) && ((vmode == 1) ? (cyc % 3 == 0) : 1'b1);
         pixel_in  = in_valid ? src[idx] : 8'h00;
         start     = (restart != 0) && (n == 2*W + 1) && !restarted;
         if (start) restarted = 1'b1;
         #1;
         if (prev_hold && (!out_valid || pixel_out !== prev_pix)) hold_err++;
         if (expect_starve) begin
            starve_seen++;
            if (out_valid) starve_err++;
         end
         phase_b = (((n / (2*W)) % 2) == 1) && (n < TOTAL);
         if (phase_b && in_ready) rowb_err++;
         if (!phase_b && out_valid && (n % 2 == 0) && in_ready) inrdy_err++;
         if (done) begin
            done_hi++;
            if (done_cyc < 0) begin
               done_cyc = cyc;
               done_lat = cyc - t_last;
            end
         end
         if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = busy;
         in_x  = in_valid && in_ready;
         out_x = out_valid && out_ready;
         expect_starve = 1'b0;
         if (out_x) begin
            got.push_back(pixel_out);
            if (!phase_b && (n % 2 == 1) && (((n / 2) % W) != W - 1) && !in_x) expect_starve = 1'b1;
            n++;
            t_last = cyc;
         end
         if (in_x) idx++;
         prev_hold = out_valid && !out_ready;
         prev_pix  = pixel_out;
         if (stop_after > 0 && n == stop_after) break;
         if (done_cyc >= 0 && cyc == done_cyc + 2) break;
         @(negedge clk);
      end
      start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_checks++; if (pixel_out !== 8'h00) begin n_fail++; $display("FAIL reset_pixel_out: got %0h expected 0", pixel_out); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
`ifdef PIXEL_REPLICATION_COUNT_EN
      n_checks++; if (out_count !== 32'd0) begin n_fail++; $display("FAIL reset_out_count: got %0d expected 0", out_count); end
`endif
      @(negedge clk); reset_n = 1'b1;
   endtask

   task automatic test_basic();
      run_frame(0, 0, 0, 0);
      n_checks++; if (got.size() != TOTAL) begin n_fail++; $display("FAIL basic_count: got %0d expected %0d", got.size(), TOTAL); end
      for (int i = 0; i < TOTAL; i++) begin
         n_checks++;
         if (i >= got.size() || got[i] !== exp_seq[i]) begin
            n_fail++; $display("FAIL basic_pix[%0d]: got %0d expected %0d", i, (i < got.size()) ? got[i] : 8'h00, exp_seq[i]);
         end
      end
      n_checks++; if (done_hi != 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d expected 1", done_hi); end
      n_checks++; if (done_lat != 1) begin n_fail++; $display("FAIL basic_done_latency: got %0d expected 1", done_lat); end
      n_checks++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after_done: got %b expected 0", busy_after); end
      n_checks++; if (inrdy_err != 0) begin n_fail++; $display("FAIL basic_in_ready_first_copy: got %0d expected 0", inrdy_err); end
`ifdef PIXEL_REPLICATION_COUNT_EN
      n_checks++; if (out_count !== 32'd32) begin n_fail++; $display("FAIL basic_out_count: got %0d expected 32", out_count); end
`endif
   endtask

   task automatic test_backpressure();
      run_frame(1, 0, 0, 0);
      n_checks++; if (got.size() != TOTAL) begin n_fail++; $display("FAIL bp_count: got %0d expected %0d", got.size(), TOTAL); end
      for (int i = 0; i < TOTAL; i++) begin
         n_checks++;
         if (i >= got.size() || got[i] !== exp_seq[i]) begin
            n_fail++; $display("FAIL bp_pix[%0d]: got %0d expected %0d", i, (i < got.size()) ? got[i] : 8'h00, exp_seq[i]);
         end
      end
      n_checks++; if (hold_err != 0) begin n_fail++; $display("FAIL bp_hold_stable: got %0d expected 0", hold_err); end
      n_checks++; if (inrdy_err != 0) begin n_fail++; $display("FAIL bp_in_ready_first_copy: got %0d expected 0", inrdy_err); end
      n_checks++; if (done_hi != 1) begin n_fail++; $display("FAIL bp_done_pulses: got %0d expected 1", done_hi); end
   endtask

   task automatic test_input_gaps();
      run_frame(0, 1, 0, 0);
      n_checks++; if (got.size() != TOTAL) begin n_fail++; $display("FAIL gaps_count: got %0d expected %0d", got.size(), TOTAL); end
      for (int i = 0; i < TOTAL; i++) begin
         n_checks++;
         if (i >= got.size() || got[i] !== exp_seq[i]) begin
            n_fail++; $display("FAIL gaps_pix[%0d]: got %0d expected %0d", i, (i < got.size()) ? got[i] : 8'h00, exp_seq[i]);
         end
      end
      n_checks++; if (starve_seen == 0) begin n_fail++; $display("FAIL gaps_starve_seen: got 0 expected >0"); end
      n_checks++; if (starve_err != 0) begin n_fail++; $display("FAIL gaps_out_valid_starved: got %0d expected 0", starve_err); end
      n_checks++; if (rowb_err != 0) begin n_fail++; $display("FAIL gaps_in_ready_row_b: got %0d expected 0", rowb_err); end
   endtask

   task automatic test_restart_ignored();
      run_frame(0, 0, 1, 0);
      n_checks++; if (got.size() != TOTAL) begin n_fail++; $display("FAIL restart_count: got %0d expected %0d", got.size(), TOTAL); end
      for (int i = 0; i < TOTAL; i++) begin
         n_checks++;
         if (i >= got.size() || got[i] !== exp_seq[i]) begin
            n_fail++; $display("FAIL restart_pix[%0d]: got %0d expected %0d", i, (i < got.size()) ? got[i] : 8'h00, exp_seq[i]);
         end
      end
      n_checks++; if (done_hi != 1) begin n_fail++; $display("FAIL restart_done_pulses: got %0d expected 1", done_hi); end
   endtask

   task automatic test_reset_mid_frame();
      run_frame(0, 0, 0, 3);
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      n_checks++; if (pixel_out !== 8'h00) begin n_fail++; $display("FAIL midrst_pixel_out: got %0h expected 0", pixel_out); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", done); end
      @(negedge clk); reset_n = 1'b1;
      run_frame(0, 0, 0, 0);
      n_checks++; if (got.size() != TOTAL) begin n_fail++; $display("FAIL midrst_count: got %0d expected %0d", got.size(), TOTAL); end
      for (int i = 0; i < TOTAL; i++) begin
         n_checks++;
         if (i >= got.size() || got[i] !== exp_seq[i]) begin
            n_fail++; $display("FAIL midrst_pix[%0d]: got %0d expected %0d", i, (i < got.size()) ? got[i] : 8'h00, exp_seq[i]);
         end
      end
      n_checks++; if (done_hi != 1) begin n_fail++; $display("FAIL midrst_done_pulses: got %0d expected 1", done_hi); end
   endtask

   task automatic test_single_pixel();
      int   outs = 0;
      int   dh   = 0;
      logic took;
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      in_valid1 = 1'b1; pixel_in1 = 8'hAB; out_ready1 = 1'b1;
      for (int c = 0; c < 40; c++) begin
         #1;
         took = in_valid1 && in_ready1;
         if (out_valid1 && out_ready1) begin
            outs++;
            n_checks++;
            if (pixel_out1 !== 8'hAB) begin n_fail++; $display("FAIL single_pix[%0d]: got %0h expected ab", outs, pixel_out1); end
         end
         if (done1) dh++;
         @(negedge clk);
         if (took) in_valid1 = 1'b0;
      end
      n_checks++; if (outs != 4) begin n_fail++; $display("FAIL single_count: got %0d expected 4", outs); end
      n_checks++; if (dh != 1) begin n_fail++; $display("FAIL single_done_pulses: got %0d expected 1", dh); end
      n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b expected 0", busy1); end
`ifdef PIXEL_REPLICATION_COUNT_EN
      n_checks++; if (out_count1 !== 32'd4) begin n_fail++; $display("FAIL single_out_count: got %0d expected 4", out_count1); end
`endif
   endtask

   initial begin
      reset_n = 1'b0;
      start = 1'b0; in_valid = 1'b0; pixel_in = 8'h00; out_ready = 1'b0;
      start1 = 1'b0; in_valid1 = 1'b0; pixel_in1 = 8'h00; out_ready1 = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      test_basic();
      test_backpressure();
      test_input_gaps();
      test_restart_ignored();
      test_reset_mid_frame();
      test_single_pixel();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
